// File: rtl/bridge_gate_sequencer.sv
// Purpose: full-bridge gate sequencer that commutates diagonals A/B on ZCS edges, with dead time, blanking, watchdog and fault shutdown.
// Latency: gates are registered decodes of the next state, so a qualifying ZCS edge or a fault in cycle N turns the gates off in cycle N+1.
// Backpressure: none; enable is a level request and a drive half-cycle in progress always runs to its ZCS edge.
module bridge_gate_sequencer #(
  parameter int CNT_W      = 16,
  parameter int DEAD_TIME  = 8,
  parameter int START_HALF = 400,
  parameter int MIN_HALF   = 100,
  parameter int MAX_HALF   = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             zcs,
  input  logic             fault,
  input  logic             flag_clear,
  output logic             gate1,
  output logic             gate2,
  output logic             gate3,
  output logic             gate4,
  output logic             running,
  output logic [CNT_W-1:0] half_cycles,
  output logic             timeout_flag,
  output logic             fault_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DEAD_AB,
    S_DRIVE_B,
    S_DEAD_BA,
    S_DRIVE_A,
    S_STOP,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HALF - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_HALF - 1);
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_HALF);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             zcs_q;
  logic             zcs_edge;
  logic             zcs_ok;
  logic             set_timeout;
  logic             drive_exit;
  logic             diag_a_nxt;
  logic             diag_b_nxt;

  // Either comparator polarity marks a current zero crossing; edges are
  // only trusted once the half-cycle is past the ringing blanking window.
  assign zcs_edge = zcs ^ zcs_q;
  assign zcs_ok   = zcs_edge && (cnt >= MIN_CNT);

  assign running  = (state != S_IDLE) && (state != S_FAULT);

  // Next-state: fault overrides everything; a qualifying edge beats the watchdog.
  always_comb begin
    state_nxt   = state;
    set_timeout = 1'b0;
    if (fault) begin
      state_nxt = S_FAULT;
    end else begin
      case (state)
        S_IDLE:    if (enable) state_nxt = S_START;
        S_START:   if (cnt == START_LAST) state_nxt = S_DEAD_AB;
        S_DEAD_AB: if (cnt == DEAD_LAST) state_nxt = enable ? S_DRIVE_B : S_IDLE;
        S_DRIVE_B: begin
          if (zcs_ok) begin
            state_nxt = S_DEAD_BA;
          end else if (cnt == MAX_LAST) begin
            state_nxt   = S_STOP;
            set_timeout = 1'b1;
          end
        end
        S_DEAD_BA: if (cnt == DEAD_LAST) state_nxt = enable ? S_DRIVE_A : S_IDLE;
        S_DRIVE_A: begin
          if (zcs_ok) begin
            state_nxt = S_DEAD_AB;
          end else if (cnt == MAX_LAST) begin
            state_nxt   = S_STOP;
            set_timeout = 1'b1;
          end
        end
        S_STOP:    if (cnt == DEAD_LAST) state_nxt = S_IDLE;
        S_FAULT:   if (!enable) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  assign drive_exit = ((state == S_START) || (state == S_DRIVE_A) || (state == S_DRIVE_B))
                      && (state_nxt != state);
  assign diag_a_nxt = (state_nxt == S_START) || (state_nxt == S_DRIVE_A);
  assign diag_b_nxt = (state_nxt == S_DRIVE_B);

  // State register; the counter restarts on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
    end
  end

  // Previous comparator level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zcs_q <= 1'b0;
    else        zcs_q <= zcs;
  end

  // Gates follow the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate1 <= 1'b0;
      gate2 <= 1'b0;
      gate3 <= 1'b0;
      gate4 <= 1'b0;
    end else begin
      gate1 <= diag_a_nxt;
      gate4 <= diag_a_nxt;
      gate2 <= diag_b_nxt;
      gate3 <= diag_b_nxt;
    end
  end

  // Half-cycle count: cleared at burst start, saturating on each drive exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cycles <= '0;
    end else if ((state == S_IDLE) && (state_nxt == S_START)) begin
      half_cycles <= '0;
    end else if (drive_exit && (half_cycles != {CNT_W{1'b1}})) begin
      half_cycles <= half_cycles + 1'b1;
    end
  end

  // Sticky flags; a set in the same cycle as flag_clear keeps the flag up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
      fault_flag   <= 1'b0;
    end else begin
      if (set_timeout)     timeout_flag <= 1'b1;
      else if (flag_clear) timeout_flag <= 1'b0;
      if (fault)           fault_flag <= 1'b1;
      else if (flag_clear) fault_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bridge_gate_sequencer.sv
// Purpose: directed bench for bridge_gate_sequencer covering startup, closed loop, blanking, watchdog, graceful stop, fault and reset.
// Latency: outputs sampled on the falling edge, half a cycle after the registering edge.
// Backpressure: not applicable; every wait on the DUT is bounded.
module tb_bridge_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        zcs = 1'b0;
  logic        fault = 1'b0;
  logic        flag_clear = 1'b0;
  logic        gate1, gate2, gate3, gate4;
  logic        running;
  logic [15:0] half_cycles;
  logic        timeout_flag;
  logic        fault_flag;

  localparam logic [3:0] G_A   = 4'b1001;
  localparam logic [3:0] G_B   = 4'b0110;
  localparam logic [3:0] G_OFF = 4'b0000;

  int   n_chk = 0;
  int   n_pass = 0;
  int   overlaps = 0;
  int   len;
  logic [3:0] g;

  assign g = {gate1, gate2, gate3, gate4};

  always #5 clk = ~clk;

  bridge_gate_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .zcs          (zcs),
    .fault        (fault),
    .flag_clear   (flag_clear),
    .gate1        (gate1),
    .gate2        (gate2),
    .gate3        (gate3),
    .gate4        (gate4),
    .running      (running),
    .half_cycles  (half_cycles),
    .timeout_flag (timeout_flag),
    .fault_flag   (fault_flag)
  );

  // Shoot-through watch on every sampled cycle.
  always @(negedge clk) begin
    if ((gate1 & gate2) | (gate3 & gate4) | ((gate1 | gate4) & (gate2 | gate3)))
      overlaps++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts consecutive sampled cycles showing pattern pat, starting now.
  task automatic measure(input logic [3:0] pat, output int n);
    n = 0;
    while ((g == pat) && (n < 5000)) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    // Reset values
    wait_n(3);
    check_eq("rst_gates", g, G_OFF);
    check_eq("rst_running", running, 0);
    check_eq("rst_half", half_cycles, 0);
    check_eq("rst_tflag", timeout_flag, 0);
    check_eq("rst_fflag", fault_flag, 0);

    // Startup: 400 cycles of A, 8 dead, then B
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_n(1);
    check_eq("start_a_on", g, G_A);
    check_eq("start_running", running, 1);
    measure(G_A, len);
    check_eq("start_a_len", len, 400);
    measure(G_OFF, len);
    check_eq("start_dead_len", len, 8);
    check_eq("start_b_on", g, G_B);
    check_eq("start_half", half_cycles, 1);

    // Closed loop: ZCS toggle at count 499 ends B after 500 cycles
    wait_n(499);
    check_eq("cl_b_hold", g, G_B);
    zcs = ~zcs;
    wait_n(1);
    check_eq("cl_b_drop", g, G_OFF);
    measure(G_OFF, len);
    check_eq("cl_dead_ba", len, 8);
    check_eq("cl_a_on", g, G_A);
    check_eq("cl_half2", half_cycles, 2);

    // Blanking: edge at count 50 ignored, edge at count 100 commutates
    wait_n(50);
    zcs = ~zcs;
    wait_n(1);
    check_eq("blank_hold", g, G_A);
    wait_n(49);
    zcs = ~zcs;
    wait_n(1);
    check_eq("blank_commutate", g, G_OFF);
    measure(G_OFF, len);
    check_eq("blank_dead", len, 8);
    check_eq("blank_b_on", g, G_B);
    check_eq("blank_half3", half_cycles, 3);

    // One more normal commutation back to A
    wait_n(499);
    zcs = ~zcs;
    wait_n(1);
    measure(G_OFF, len);
    check_eq("cl_dead_ba2", len, 8);
    check_eq("cl_a_on2", g, G_A);
    check_eq("cl_half4", half_cycles, 4);

    // Graceful stop: enable drops at count 200, edge 300 cycles later
    wait_n(200);
    enable = 1'b0;
    wait_n(299);
    check_eq("gs_still_a", g, G_A);
    wait_n(1);
    zcs = ~zcs;
    wait_n(1);
    check_eq("gs_gates_off", g, G_OFF);
    check_eq("gs_dead_running", running, 1);
    wait_n(7);
    check_eq("gs_dead_last", running, 1);
    wait_n(1);
    check_eq("gs_idle", running, 0);
    check_eq("gs_half5", half_cycles, 5);
    wait_n(20);
    check_eq("gs_no_redrive", g, G_OFF);

    // Watchdog: hold zcs in B, enable already dropped
    enable = 1'b1;
    wait_n(1);
    check_eq("wd_half_clr", half_cycles, 0);
    measure(G_A, len);
    check_eq("wd_start_len", len, 400);
    measure(G_OFF, len);
    check_eq("wd_b_on", g, G_B);
    enable = 1'b0;
    wait_n(1999);
    check_eq("wd_b_hold", g, G_B);
    check_eq("wd_tflag_pre", timeout_flag, 0);
    wait_n(1);
    check_eq("wd_gates_off", g, G_OFF);
    check_eq("wd_tflag", timeout_flag, 1);
    wait_n(7);
    check_eq("wd_stop_running", running, 1);
    wait_n(1);
    check_eq("wd_idle", running, 0);
    flag_clear = 1'b1;
    wait_n(1);
    flag_clear = 1'b0;
    check_eq("wd_tflag_clr", timeout_flag, 0);

    // Edge on the last watchdog cycle wins: normal commutation, no flag
    enable = 1'b1;
    wait_n(1);
    measure(G_A, len);
    measure(G_OFF, len);
    check_eq("ew_b_on", g, G_B);
    wait_n(1999);
    zcs = ~zcs;
    wait_n(1);
    check_eq("ew_gates_off", g, G_OFF);
    check_eq("ew_no_flag", timeout_flag, 0);
    measure(G_OFF, len);
    check_eq("ew_dead_len", len, 8);
    check_eq("ew_a_on", g, G_A);

    // Fault with a simultaneous ZCS edge in B
    wait_n(499);
    zcs = ~zcs;
    wait_n(1);
    measure(G_OFF, len);
    check_eq("flt_b_on", g, G_B);
    wait_n(200);
    fault = 1'b1;
    zcs   = ~zcs;
    wait_n(1);
    check_eq("flt_gates_off", g, G_OFF);
    check_eq("flt_fflag", fault_flag, 1);
    check_eq("flt_running", running, 0);
    flag_clear = 1'b1;
    wait_n(1);
    flag_clear = 1'b0;
    check_eq("flt_set_wins", fault_flag, 1);
    wait_n(10);
    check_eq("flt_hold_gates", g, G_OFF);
    check_eq("flt_hold_running", running, 0);
    fault = 1'b0;
    wait_n(5);
    check_eq("flt_hold_enable", g, G_OFF);
    check_eq("flt_hold_en_run", running, 0);
    enable = 1'b0;
    wait_n(2);
    check_eq("flt_sticky", fault_flag, 1);
    enable = 1'b1;
    wait_n(1);
    check_eq("flt_restart", g, G_A);
    flag_clear = 1'b1;
    wait_n(1);
    flag_clear = 1'b0;
    check_eq("flt_fflag_clr", fault_flag, 0);

    // Asynchronous reset mid-drive
    wait_n(50);
    check_eq("rst_pre_a", g, G_A);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_gates", g, G_OFF);
    check_eq("rst_async_running", running, 0);
    wait_n(2);
    rst_n  = 1'b1;
    enable = 1'b0;

    check_eq("no_overlap", overlaps, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bridge_gate_sequencer.md
Name: bridge_gate_sequencer

Overview:
- Sequences the four full-bridge gate drives (diagonal A = gate1+gate4, diagonal B = gate2+gate3) of the resonant primary, commutating on zero-current-sense (ZCS) edges with programmable dead time.
- Sits between the interrupter/enable logic (fiber-derived burst enable) and the GATE1..GATE4 pins in controller_top.
- Provides an open-loop start kick, ZCS blanking, a missed-ZCS watchdog and a hard fault shutdown.

Parameters:
- CNT_W, 16, width of the half-cycle/dead-time counter.
- DEAD_TIME, 8, clock cycles with all gates low between diagonals.
- START_HALF, 400, fixed length in cycles of the first (open-loop) diagonal-A half-cycle.
- MIN_HALF, 100, blanking: ZCS edges ignored while drive counter < MIN_HALF.
- MAX_HALF, 2000, watchdog: drive state reaching this count without a ZCS edge ends the burst.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  burst request, already synchronous to clk
- zcs  in  1  zero-current comparator, already 2-flop synchronised to clk
- fault  in  1  synchronous fault (over-temp/over-current), level
- flag_clear  in  1  one-cycle pulse, clears sticky flags
- gate1, gate2, gate3, gate4  out  1 each  registered gate commands
- running  out  1  high while in any state other than IDLE/FAULT
- half_cycles  out  CNT_W  completed drive half-cycles in current burst, saturating
- timeout_flag  out  1  sticky: watchdog expired
- fault_flag  out  1  sticky: fault shutdown occurred

Behaviour:
- Reset (async, rst_n low): state IDLE, all gates 0, running 0, half_cycles 0, both flags 0, counter 0, zcs_q 0.
- zcs_q registers zcs every cycle; zcs_edge = zcs ^ zcs_q (either polarity).
- Counter clears on every state entry and increments by 1 per cycle in the state.
- Gate outputs are registered decodes of the next state: A states drive gate1=gate4=1, B states drive gate2=gate3=1, all other states drive 0. gate1/gate2 and gate3/gate4 are never simultaneously 1.
- States and transitions:
  - IDLE: enable=1 -> START, half_cycles <= 0.
  - START: diagonal A on; counter == START_HALF-1 -> DEAD_AB; ZCS ignored.
  - DEAD_AB: all off; counter == DEAD_TIME-1 -> (enable ? DRIVE_B : IDLE).
  - DRIVE_B: diagonal B on; (zcs_edge and counter >= MIN_HALF) -> DEAD_BA; counter == MAX_HALF-1 with no qualifying edge -> STOP, timeout_flag <= 1.
  - DEAD_BA: all off; counter == DEAD_TIME-1 -> (enable ? DRIVE_A : IDLE).
  - DRIVE_A: diagonal A on; same exits as DRIVE_B, going to DEAD_AB.
  - STOP: all off for DEAD_TIME cycles -> IDLE.
  - FAULT: all off; leave to IDLE only when fault=0 and enable=0.
- Commutation latency: a qualifying zcs_edge in cycle N gives all gates 0 in cycle N+1.
- half_cycles increments on each exit from START/DRIVE_A/DRIVE_B and saturates at all-ones.
- enable deassertion never truncates a drive half-cycle. The bridge finishes the current half-cycle at the ZCS edge, then runs the dead time, then returns to IDLE. This gives zero-current turn-off.
- fault=1 in any state: next state FAULT, gates 0 the following cycle, fault_flag <= 1. Fault has priority over every other transition, including ZCS and watchdog in the same cycle.
- flag_clear clears both sticky flags. If a set condition and flag_clear occur in the same cycle, set wins.
- Timeout and a qualifying edge in the same cycle: the edge wins (normal commutation, no flag).
- running = 0 in IDLE and FAULT, 1 otherwise.

Test Plan:
- Startup: enable=1 at t0 -> gate1/gate4 high for exactly 400 cycles, then 8 cycles all low, then gate2/gate3 high; half_cycles=1.
- Closed loop: toggle zcs every 500 cycles once in DRIVE_B -> diagonals alternate, each separated by exactly 8 all-low cycles. Each gate drops 1 cycle after the zcs toggle. Overlap checker never fires.
- Blanking: zcs toggle at counter=50 in DRIVE_A -> ignored, gates unchanged; a toggle at counter=100 commutates.
- Watchdog: hold zcs constant in DRIVE_B -> gates low after 2000 cycles, timeout_flag=1, IDLE after 8 more cycles. flag_clear -> flag 0.
- Graceful stop: drop enable mid-DRIVE_A, zcs edge 300 cycles later -> drive continues until that edge, then 8 dead cycles, then IDLE with no new drive.
- Fault: assert fault mid-DRIVE_B together with a zcs edge -> all gates 0 next cycle, fault_flag=1, state holds FAULT while enable=1. It returns to IDLE after fault=0 and enable=0. Also check async rst_n mid-drive -> gates 0 immediately.
